// File: rtl/lif_param_serializer.sv
// ----------------------------------------------------------------------------
// lif_param_serializer
//
// Serial configuration transmitter for the LIF neuron system. One accepted
// start captures a full parameter set into a 35-bit frame and shifts it out
// MSB first on load_mode/serial_data. After the frame, IDLE_GAP enabled
// cycles follow with load_mode low, and then a one-cycle done pulse.
//
// Frame layout, F[34] sent first:
//   {weight_a[2:0], leak_rate_1[7:0], leak_rate_2[7:0], threshold[7:0],
//    leak_cycles_1[3:0], leak_cycles_2[3:0]}
//
// Parameters:
//   IDLE_GAP     enabled low-load_mode cycles between the last bit and done
//                (legal range 1..15)
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   enable        global advance qualifier; everything holds while low
//   start         transmit request, sampled only in IDLE with enable high
//   weight_a      channel A weight (3)
//   leak_rate_1   first leak rate (8)
//   leak_rate_2   second leak rate (8)
//   threshold     firing threshold (8)
//   leak_cycles_1 first leak period (4)
//   leak_cycles_2 second leak period (4)
//   load_mode     frame-valid strobe, high for 35 enabled cycles per frame
//   serial_data   current frame bit, 0 whenever load_mode is low
//   busy          frame or gap in progress
//   done          one-cycle pulse when frame and gap complete
// ----------------------------------------------------------------------------
module lif_param_serializer #(
  parameter int unsigned IDLE_GAP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic [2:0] weight_a,
  input  logic [7:0] leak_rate_1,
  input  logic [7:0] leak_rate_2,
  input  logic [7:0] threshold,
  input  logic [3:0] leak_cycles_1,
  input  logic [3:0] leak_cycles_2,
  output logic       load_mode,
  output logic       serial_data,
  output logic       busy,
  output logic       done
);

  // Fixed by the field list; deliberately not a parameter.
  localparam int unsigned FRAME_BITS = 35;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t                  state, state_n;
  logic [FRAME_BITS-1:0]   shreg, shreg_n;
  logic [5:0]              bit_cnt, bit_cnt_n;
  logic [3:0]              gap_cnt, gap_cnt_n;
  logic                    load_mode_n, serial_data_n, busy_n, done_n;
  logic [FRAME_BITS-1:0]   frame;

  assign frame = {weight_a, leak_rate_1, leak_rate_2, threshold,
                  leak_cycles_1, leak_cycles_2};

  // Next-state and next-output logic. Outputs are computed here and then
  // registered, so no input reaches an output without passing a flop.
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first so that
    // no path leaves it unassigned, which would otherwise infer a latch.
    state_n       = state;
    shreg_n       = shreg;
    bit_cnt_n     = bit_cnt;
    gap_cnt_n     = gap_cnt;
    load_mode_n   = load_mode;
    serial_data_n = serial_data;
    busy_n        = busy;
    // done is a strict one-cycle pulse and clears even while enable is low.
    done_n        = 1'b0;

    if (enable) begin
      unique case (state)
        IDLE: begin
          load_mode_n   = 1'b0;
          serial_data_n = 1'b0;
          busy_n        = 1'b0;
          if (start) begin
            state_n       = SHIFT;
            shreg_n       = frame;
            bit_cnt_n     = 6'(FRAME_BITS - 1);
            load_mode_n   = 1'b1;
            serial_data_n = frame[FRAME_BITS-1];
            busy_n        = 1'b1;
          end
        end

        SHIFT: begin
          if (bit_cnt == 6'd0) begin
            // Bit 0 has been on the line for one enabled cycle.
            state_n       = GAP;
            gap_cnt_n     = 4'd0;
            load_mode_n   = 1'b0;
            serial_data_n = 1'b0;
          end else begin
            shreg_n       = {shreg[FRAME_BITS-2:0], 1'b0};
            bit_cnt_n     = bit_cnt - 6'd1;
            // Present the bit that becomes the MSB after this shift.
            serial_data_n = shreg[FRAME_BITS-2];
          end
        end

        GAP: begin
          if (gap_cnt == 4'(IDLE_GAP - 1)) begin
            state_n   = IDLE;
            gap_cnt_n = 4'd0;
            busy_n    = 1'b0;
            done_n    = 1'b1;
          end else begin
            gap_cnt_n = gap_cnt + 4'd1;
          end
        end

        default: begin
          state_n       = IDLE;
          load_mode_n   = 1'b0;
          serial_data_n = 1'b0;
          busy_n        = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      load_mode   <= 1'b0;
      serial_data <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      bit_cnt     <= bit_cnt_n;
      gap_cnt     <= gap_cnt_n;
      load_mode   <= load_mode_n;
      serial_data <= serial_data_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_lif_param_serializer.sv
// ----------------------------------------------------------------------------
// tb_lif_param_serializer
//
// Self-checking bench for lif_param_serializer. A table of parameter sets
// with hand-written expected frames drives the single-frame checks; the
// multi-cycle corners (enable stall, capture isolation, mid-frame reset,
// idle quiet, back-to-back) are written as explicit sequences. A second
// instance built with IDLE_GAP=4 is used for the back-to-back case.
// ----------------------------------------------------------------------------
module tb_lif_param_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       start1, start4;
  logic [2:0] weight_a;
  logic [7:0] leak_rate_1, leak_rate_2, threshold;
  logic [3:0] leak_cycles_1, leak_cycles_2;
  logic       lm1, sd1, busy1, done1;
  logic       lm4, sd4, busy4, done4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lif_param_serializer #(.IDLE_GAP(1)) dut1 (
    .clk(clk), .reset(reset), .enable(enable), .start(start1),
    .weight_a(weight_a), .leak_rate_1(leak_rate_1), .leak_rate_2(leak_rate_2),
    .threshold(threshold), .leak_cycles_1(leak_cycles_1),
    .leak_cycles_2(leak_cycles_2),
    .load_mode(lm1), .serial_data(sd1), .busy(busy1), .done(done1)
  );

  lif_param_serializer #(.IDLE_GAP(4)) dut4 (
    .clk(clk), .reset(reset), .enable(enable), .start(start4),
    .weight_a(weight_a), .leak_rate_1(leak_rate_1), .leak_rate_2(leak_rate_2),
    .threshold(threshold), .leak_cycles_1(leak_cycles_1),
    .leak_cycles_2(leak_cycles_2),
    .load_mode(lm4), .serial_data(sd4), .busy(busy4), .done(done4)
  );

  typedef struct {
    logic [2:0]  w;
    logic [7:0]  l1;
    logic [7:0]  l2;
    logic [7:0]  t;
    logic [3:0]  c1;
    logic [3:0]  c2;
    logic [34:0] frame;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply_params(input vec_t v);
    weight_a      = v.w;
    leak_rate_1   = v.l1;
    leak_rate_2   = v.l2;
    threshold     = v.t;
    leak_cycles_1 = v.c1;
    leak_cycles_2 = v.c2;
  endtask

  // Send one frame on dut1 and check stream, loader decode, done timing.
  // exp_done is the number of edges from the accepting edge to the edge
  // after which done is visible.
  task automatic run_frame(input string tag, input vec_t v, input bit stall,
                           input bit poke, input int exp_done);
    logic [34:0] rx;
    int          nbits, cyc, done_cyc, sd_bad, extra;
    bit          stalled, frozen_ok;
    logic        hold_lm, hold_sd;
    apply_params(v);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1   = 1'b0;
    rx       = '0;
    nbits    = 0;
    cyc      = 0;
    done_cyc = -1;
    sd_bad   = 0;
    stalled  = 1'b0;
    while (cyc < 300) begin
      if (!lm1 && sd1) sd_bad++;
      if (lm1) begin
        rx = {rx[33:0], sd1};
        nbits++;
      end
      if (done1) begin
        done_cyc = cyc;
        break;
      end
      if (stall && !stalled && nbits == 10) begin
        stalled   = 1'b1;
        enable    = 1'b0;
        hold_lm   = lm1;
        hold_sd   = sd1;
        frozen_ok = 1'b1;
        repeat (3) begin
          @(posedge clk); #1;
          cyc++;
          if (lm1 !== hold_lm || sd1 !== hold_sd || busy1 !== 1'b1)
            frozen_ok = 1'b0;
        end
        enable = 1'b1;
        check({tag, "_stall_frozen"}, 64'(frozen_ok), 64'd1);
      end
      if (poke && nbits == 15) begin
        threshold = 8'hFF;
        start1    = 1'b1;
      end
      if (poke && nbits == 16) start1 = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
    check({tag, "_nbits"}, 64'(nbits), 64'd35);
    check({tag, "_stream"}, 64'(rx), 64'(v.frame));
    // Loader model: split the received stream back into fields.
    check({tag, "_rx_fields"},
          64'({rx[34:32], rx[31:24], rx[23:16], rx[15:8], rx[7:4], rx[3:0]}),
          64'({v.w, v.l1, v.l2, v.t, v.c1, v.c2}));
    check({tag, "_sd_zero_when_idle"}, 64'(sd_bad), 64'd0);
    check({tag, "_busy_at_done"}, 64'(busy1), 64'd0);
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, 64'(done1), 64'd0);
    if (poke) begin
      extra = 0;
      repeat (60) begin
        if (lm1 || done1 || busy1) extra++;
        @(posedge clk); #1;
      end
      check({tag, "_no_second_frame"}, 64'(extra), 64'd0);
    end
  endtask

  initial begin
    int   cyc, nbits, act, dones, gaps, nr, budget;
    int   rises[4];
    bit   quiet_ok, found;
    logic prev_lm;

    vecs[0] = '{3'b101, 8'h0F, 8'hA5, 8'h40, 4'h3, 4'hC,
                35'b101_00001111_10100101_01000000_0011_1100};
    vecs[1] = '{3'b000, 8'h00, 8'h00, 8'h00, 4'h0, 4'h0, 35'h0};
    vecs[2] = '{3'b111, 8'hFF, 8'hFF, 8'hFF, 4'hF, 4'hF, 35'h7_FFFF_FFFF};
    vecs[3] = '{3'b010, 8'h55, 8'hAA, 8'h81, 4'h1, 4'h8,
                35'b010_01010101_10101010_10000001_0001_1000};

    reset  = 1'b1;
    enable = 1'b1;
    start1 = 1'b0;
    start4 = 1'b0;
    apply_params(vecs[0]);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_gap1", 64'({lm1, sd1, busy1, done1}), 64'd0);
    check("reset_outputs_gap4", 64'({lm4, sd4, busy4, done4}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", 64'({lm1, sd1, busy1, done1}), 64'd0);

    // Table-driven single frames.
    for (int i = 0; i < 4; i++) run_frame($sformatf("vec%0d", i), vecs[i], 1'b0, 1'b0, 36);

    // Enable stall for 3 cycles after the 10th bit.
    run_frame("stall", vecs[0], 1'b1, 1'b0, 39);

    // Capture isolation: threshold changes and start re-pulses mid-frame.
    run_frame("isolate", vecs[0], 1'b0, 1'b1, 36);

    // Mid-frame asynchronous reset at bit 20.
    apply_params(vecs[3]);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    nbits  = 0;
    cyc    = 0;
    while (nbits < 20 && cyc < 100) begin
      if (lm1) nbits++;
      if (nbits < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check("rst_reached_bit20", 64'(nbits), 64'd20);
    #2 reset = 1'b1;
    #1;
    check("rst_async_outputs", 64'({lm1, sd1, busy1, done1}), 64'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    act   = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (lm1 || done1 || busy1) act++;
    end
    check("rst_no_done_after", 64'(act), 64'd0);
    run_frame("after_rst", vecs[3], 1'b0, 1'b0, 36);

    // Idle quiet: start held while enable is low.
    apply_params(vecs[0]);
    enable   = 1'b0;
    start1   = 1'b1;
    quiet_ok = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (lm1 || sd1 || busy1 || done1) quiet_ok = 1'b0;
    end
    check("idle_quiet", 64'(quiet_ok), 64'd1);
    enable = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check("idle_begin_lm", 64'(lm1), 64'd1);
    check("idle_begin_first_bit", 64'(sd1), 64'(vecs[0].frame[34]));
    found  = 1'b0;
    budget = 0;
    while (!found && budget < 100) begin
      @(posedge clk); #1;
      budget++;
      if (done1) found = 1'b1;
    end
    check("idle_frame_done", 64'(found), 64'd1);

    // Back-to-back on the IDLE_GAP=4 instance with start held high.
    start4  = 1'b1;
    @(posedge clk); #1;
    prev_lm = 1'b0;
    nr      = 0;
    dones   = 0;
    gaps    = 0;
    for (int c = 0; c < 126; c++) begin
      if (lm4 && !prev_lm) begin
        if (nr < 4) rises[nr] = c;
        nr++;
      end
      if (done4) dones++;
      if (busy4 && !lm4) gaps++;
      prev_lm = lm4;
      @(posedge clk); #1;
    end
    start4 = 1'b0;
    check("b2b_frame_count", 64'(nr), 64'd4);
    check("b2b_first_start", 64'(rises[0]), 64'd0);
    check("b2b_period_1", 64'(rises[1] - rises[0]), 64'd40);
    check("b2b_period_2", 64'(rises[2] - rises[1]), 64'd40);
    check("b2b_done_count", 64'(dones), 64'd3);
    check("b2b_gap_cycles", 64'(gaps), 64'd12);
    found  = 1'b0;
    budget = 0;
    while (!found && budget < 100) begin
      @(posedge clk); #1;
      budget++;
      if (done4) found = 1'b1;
    end
    check("b2b_drain_done", 64'(found), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_idle_after", 64'({lm4, busy4, done4}), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
